pattern_timing_gen: RTL and testbench

//  Line/frame timing source for the pattern generator; sits directly upstream of the Control FSM.

---
 rtl/pattern_pkg.sv | 55 +++++
 rtl/pattern_timing_gen_interval_cnt.sv | 45 ++++
 rtl/pattern_timing_gen.sv | 245 ++++++++++++++++++++++++
 tb/tb_pattern_timing_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// ---------------------------------------------------------------------------
// pattern_pkg
// Shared definitions for the pattern generator timing slice:
//   - timing FSM state encoding
//   - pattern mode codes carried on Mode
//   - deltaX codes carried on X, plus a helper returning the pixel step
//   - small constant helper used for sizing the interval counter
// ---------------------------------------------------------------------------
package pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FSYNC  = 3'd1,
    ST_LSYNC  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VBLANK = 3'd5
  } tstate_e;

  // Code 0 is not a valid mode; a start request carrying it is refused.
  typedef enum logic [2:0] {
    MODE_NONE     = 3'd0,
    MODE_REGULAR  = 3'd1,
    MODE_CONST    = 3'd2,
    MODE_WHITE1X1 = 3'd3,
    MODE_BLACK1X1 = 3'd4,
    MODE_WHITE2X2 = 3'd5,
    MODE_BLACK2X2 = 3'd6,
    MODE_RAMP     = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    DX_0 = 2'b00,
    DX_1 = 2'b01,
    DX_4 = 2'b10,
    DX_8 = 2'b11
  } deltax_e;

  // Pixel step for a deltaX code, as used by the downstream ramp counter.
  function automatic int unsigned deltax_step(input logic [1:0] code);
    case (code)
      2'b00:   deltax_step = 0;
      2'b01:   deltax_step = 1;
      2'b10:   deltax_step = 4;
      default: deltax_step = 8;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    max3 = (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pattern_timing_gen_interval_cnt.sv
// ---------------------------------------------------------------------------
// timing_interval_cnt
// Loadable down-counter timing one interval (ACTIVE, HBLANK or VBLANK).
// Loading N-1 makes done_o assert on the N-th cycle after the load edge.
// The counter parks at zero once an interval has run out.
// Ports:
//   clk        in  clock
//   rst_n      in  asynchronous active-low reset
//   load_i     in  load load_val_i on the next edge (priority over counting)
//   load_val_i in  interval length minus one
//   done_o     out current count is zero (last cycle of the interval)
// ---------------------------------------------------------------------------
module timing_interval_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pattern_timing_gen.sv
// ---------------------------------------------------------------------------
// pattern_timing_gen
// Line/frame timing source for the pattern generator. Generates frame and
// line strobes, blanking flags and pixel/line indices, and latches the
// pattern mode and deltaX once per frame so a frame never changes pattern.
// Every output is a register; outputs describe the state being occupied in
// the current cycle.
//
// Optional feature (macro PAT_TIMING_FRAME_CNT_EN): when defined, adds a
// 16-bit wrapping frame counter output frame_cnt that steps on each f_sync.
//
// Ports:
//   clk       in   master clock
//   rst_n     in   asynchronous active-low reset
//   enable    in   run request, sampled in IDLE and on the last VBLANK cycle
//   abort     in   synchronous abort back to IDLE (highest priority)
//   mode_in   in   requested pattern mode (0 is rejected)
//   x_in      in   requested deltaX code
//   f_sync    out  frame start pulse
//   sync      out  line start pulse
//   endLine   out  HBLANK/VBLANK flag, held until the next line start
//   endFrame  out  last line's HBLANK plus VBLANK
//   active    out  active pixel cycle
//   pix_cnt   out  active pixel index
//   line_cnt  out  current line index
//   Mode      out  mode latched at frame start
//   X         out  deltaX latched at frame start
//   cfg_err   out  pulse: start refused because mode_in was 0
//   busy      out  not idle
//   frame_cnt out  frames started (only with PAT_TIMING_FRAME_CNT_EN)
// ---------------------------------------------------------------------------
module pattern_timing_gen
  import pattern_pkg::*;
#(
  parameter int PIX_PER_LINE    = 4096,
  parameter int LINES_PER_FRAME = 32,
  parameter int HBLANK          = 8,
  parameter int VBLANK          = 16,
  parameter int PIX_W           = 12,
  parameter int LINE_W          = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              abort,
  input  logic [2:0]        mode_in,
  input  logic [1:0]        x_in,
  output logic              f_sync,
  output logic              sync,
  output logic              endLine,
  output logic              endFrame,
  output logic              active,
  output logic [PIX_W-1:0]  pix_cnt,
  output logic [LINE_W-1:0] line_cnt,
  output logic [2:0]        Mode,
  output logic [1:0]        X,
`ifdef PAT_TIMING_FRAME_CNT_EN
  output logic [15:0]       frame_cnt,
`endif
  output logic              cfg_err,
  output logic              busy
);

  localparam int IV_MAX = max3(PIX_PER_LINE, HBLANK, VBLANK);
  localparam int CNT_W  = (IV_MAX < 2) ? 1 : $clog2(IV_MAX);

  localparam logic [CNT_W-1:0]  ACT_LOAD  = CNT_W'(PIX_PER_LINE - 1);
  localparam logic [CNT_W-1:0]  HBL_LOAD  = CNT_W'(HBLANK - 1);
  localparam logic [CNT_W-1:0]  VBL_LOAD  = CNT_W'(VBLANK - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES_PER_FRAME - 1);

  tstate_e           state_q;
  logic              f_sync_q, sync_q, endline_q, endframe_q, active_q;
  logic              cfg_err_q, busy_q;
  logic [PIX_W-1:0]  pix_q;
  logic [LINE_W-1:0] line_q;
  logic [2:0]        mode_q;
  logic [1:0]        x_q;
`ifdef PAT_TIMING_FRAME_CNT_EN
  logic [15:0]       frame_cnt_q;
`endif

  logic             iv_load;
  logic [CNT_W-1:0] iv_val;
  logic             iv_done;
  logic             last_line;
  logic             start_ok;

  assign last_line = (line_q == LAST_LINE);

  // A frame may start from IDLE or straight out of the last VBLANK cycle.
  assign start_ok = !abort && enable && (mode_in != MODE_NONE) &&
                    ((state_q == ST_IDLE) || ((state_q == ST_VBLANK) && iv_done));

  // The interval counter is loaded on the edge that enters each timed
  // interval, so its done flag marks that interval's final cycle.
  always_comb begin
    iv_load = 1'b0;
    iv_val  = '0;
    case (state_q)
      ST_LSYNC: begin
        iv_load = 1'b1;
        iv_val  = ACT_LOAD;
      end
      ST_ACTIVE: begin
        if (iv_done) begin
          iv_load = 1'b1;
          iv_val  = HBL_LOAD;
        end
      end
      ST_HBLANK: begin
        if (iv_done && last_line) begin
          iv_load = 1'b1;
          iv_val  = VBL_LOAD;
        end
      end
      default: ;
    endcase
  end

  timing_interval_cnt #(.W(CNT_W)) u_iv_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (iv_load),
    .load_val_i (iv_val),
    .done_o     (iv_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      f_sync_q    <= 1'b0;
      sync_q      <= 1'b0;
      endline_q   <= 1'b0;
      endframe_q  <= 1'b0;
      active_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      pix_q       <= '0;
      line_q      <= '0;
      mode_q      <= '0;
      x_q         <= '0;
`ifdef PAT_TIMING_FRAME_CNT_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      f_sync_q  <= 1'b0;
      sync_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (abort) begin
        // Mode/X and the frame counter deliberately survive an abort.
        state_q    <= ST_IDLE;
        endline_q  <= 1'b0;
        endframe_q <= 1'b0;
        active_q   <= 1'b0;
        busy_q     <= 1'b0;
        pix_q      <= '0;
        line_q     <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (enable && (mode_in == MODE_NONE)) begin
              cfg_err_q <= 1'b1;
            end
          end
          ST_FSYNC: begin
            state_q    <= ST_LSYNC;
            sync_q     <= 1'b1;
            pix_q      <= '0;
            endline_q  <= 1'b0;
            endframe_q <= 1'b0;
          end
          ST_LSYNC: begin
            state_q  <= ST_ACTIVE;
            active_q <= 1'b1;
          end
          ST_ACTIVE: begin
            if (iv_done) begin
              state_q    <= ST_HBLANK;
              active_q   <= 1'b0;
              endline_q  <= 1'b1;
              endframe_q <= last_line;
            end else begin
              pix_q <= pix_q + 1'b1;
            end
          end
          ST_HBLANK: begin
            if (iv_done) begin
              if (last_line) begin
                state_q <= ST_VBLANK;
              end else begin
                state_q    <= ST_LSYNC;
                line_q     <= line_q + 1'b1;
                sync_q     <= 1'b1;
                pix_q      <= '0;
                endline_q  <= 1'b0;
                endframe_q <= 1'b0;
              end
            end
          end
          ST_VBLANK: begin
            // Back-to-back frames keep endLine/endFrame through FSYNC;
            // they drop at the following line start.
            if (iv_done && !start_ok) begin
              state_q    <= ST_IDLE;
              endline_q  <= 1'b0;
              endframe_q <= 1'b0;
              busy_q     <= 1'b0;
              cfg_err_q  <= enable;
            end
          end
          default: state_q <= ST_IDLE;
        endcase

        if (start_ok) begin
          state_q     <= ST_FSYNC;
          f_sync_q    <= 1'b1;
          busy_q      <= 1'b1;
          line_q      <= '0;
          mode_q      <= mode_in;
          x_q         <= x_in;
`ifdef PAT_TIMING_FRAME_CNT_EN
          frame_cnt_q <= frame_cnt_q + 1'b1;
`endif
        end
      end
    end
  end

  assign f_sync    = f_sync_q;
  assign sync      = sync_q;
  assign endLine   = endline_q;
  assign endFrame  = endframe_q;
  assign active    = active_q;
  assign pix_cnt   = pix_q;
  assign line_cnt  = line_q;
  assign Mode      = mode_q;
  assign X         = x_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;
`ifdef PAT_TIMING_FRAME_CNT_EN
  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_pattern_timing_gen.sv
`timescale 1ns/1ps
// Bench for pattern_timing_gen with a small geometry. The reference model
// tracks only the cycle position within a frame and derives every output
// arithmetically from that position.
module tb_pattern_timing_gen;

  localparam int P   = 4;
  localparam int L   = 2;
  localparam int H   = 2;
  localparam int V   = 3;
  localparam int PW  = 12;
  localparam int LW  = 5;
  localparam int SEG = 1 + P + H;
  localparam int F   = 1 + L * SEG + V;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          abort = 1'b0;
  logic [2:0]    mode_in = '0;
  logic [1:0]    x_in = '0;
  logic          f_sync, sync, endLine, endFrame, active, cfg_err, busy;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  logic [2:0]    Mode;
  logic [1:0]    X;
`ifdef PAT_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  pattern_timing_gen #(
    .PIX_PER_LINE    (P),
    .LINES_PER_FRAME (L),
    .HBLANK          (H),
    .VBLANK          (V),
    .PIX_W           (PW),
    .LINE_W          (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .abort     (abort),
    .mode_in   (mode_in),
    .x_in      (x_in),
    .f_sync    (f_sync),
    .sync      (sync),
    .endLine   (endLine),
    .endFrame  (endFrame),
    .active    (active),
    .pix_cnt   (pix_cnt),
    .line_cnt  (line_cnt),
    .Mode      (Mode),
    .X         (X),
`ifdef PAT_TIMING_FRAME_CNT_EN
    .frame_cnt (frame_cnt),
`endif
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  always #30 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fs_count = 0;
  int fs_rel2  = -1;
  int base     = 0;

  // Reference model: m_t = 0 when idle, else 1..F = position in the frame.
  int m_t;
  int e_fs, e_sy, e_el, e_ef, e_act, e_cfg, e_busy;
  int e_pix, e_line, e_mode, e_x, e_fc;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    e_fs = 0; e_sy = 0; e_el = 0; e_ef = 0; e_act = 0; e_cfg = 0; e_busy = 0;
    e_pix = 0; e_line = 0; e_mode = 0; e_x = 0; e_fc = 0;
  endtask

  task automatic model_step(input int en, input int ab, input int m, input int xx);
    int u, ln, r;
    e_fs = 0; e_sy = 0; e_act = 0; e_cfg = 0;
    if (ab != 0) begin
      m_t = 0; e_el = 0; e_ef = 0; e_busy = 0; e_pix = 0; e_line = 0;
      return;
    end
    if (m_t == 0 || m_t == F) begin
      if (en != 0 && m != 0) begin
        m_t = 1; e_mode = m; e_x = xx; e_fc = (e_fc + 1) % 65536;
      end else begin
        m_t = 0; e_cfg = en;
      end
    end else begin
      m_t++;
    end
    if (m_t == 0) begin
      e_el = 0; e_ef = 0; e_busy = 0;
    end else if (m_t == 1) begin
      e_fs = 1; e_line = 0; e_busy = 1;
    end else begin
      u = m_t - 2;
      if (u < L * SEG) begin
        ln = u / SEG;
        r  = u % SEG;
        e_line = ln;
        if (r == 0) begin
          e_sy = 1; e_pix = 0; e_el = 0; e_ef = 0;
        end else if (r <= P) begin
          e_act = 1; e_pix = r - 1;
        end else begin
          e_el = 1; e_ef = (ln == L - 1) ? 1 : 0;
        end
      end else begin
        e_el = 1; e_ef = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("f_sync",   f_sync,   e_fs);
    chk("sync",     sync,     e_sy);
    chk("endLine",  endLine,  e_el);
    chk("endFrame", endFrame, e_ef);
    chk("active",   active,   e_act);
    chk("pix_cnt",  pix_cnt,  e_pix);
    chk("line_cnt", line_cnt, e_line);
    chk("Mode",     Mode,     e_mode);
    chk("X",        X,        e_x);
    chk("cfg_err",  cfg_err,  e_cfg);
    chk("busy",     busy,     e_busy);
`ifdef PAT_TIMING_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, e_fc);
`endif
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass,
  // then compare at the next falling edge.
  task automatic cycle(input int en, input int ab, input int m, input int xx);
    enable  = (en != 0);
    abort   = (ab != 0);
    mode_in = 3'(m);
    x_in    = 2'(xx);
    @(posedge clk);
    model_step(en, ab, m, xx);
    @(negedge clk);
    cyc++;
    check_all();
    if (f_sync) begin
      fs_count++;
      if (fs_count == 2) fs_rel2 = cyc - base;
    end
  endtask

  int en_r;
  int ab_r;
  int m_r;

  initial begin
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle while enable is low.
    for (int i = 0; i < 3; i++) cycle(0, 0, 7, 2);

    // Two frames back to back, mode_in changed mid-frame, enable dropped
    // during line 0 of the second frame.
    base = cyc;
    fs_count = 0;
    for (int i = 0; i < 48; i++) begin
      cycle((i < 21) ? 1 : 0, 0, (i < 5) ? 7 : 3, 2);
      if (i == 0) chk("fsync_first_rel", cyc - base, 1);
    end
    chk("fsync_second_rel", fs_rel2, F + 1);
    chk("fsync_count", fs_count, 2);
    chk("idle_after_stop", busy, 0);

    // Abort during active pixels of line 1.
    base = cyc;
    for (int i = 0; i < 11; i++) cycle(1, 0, 5, 1);
    chk("pre_abort_active", active, 1);
    chk("pre_abort_line", line_cnt, 1);
    cycle(1, 1, 5, 1);
    chk("abort_busy", busy, 0);
    chk("abort_active", active, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 5, 1);

    // Start refused with mode 0.
    cycle(1, 0, 0, 3);
    chk("cfg_err_pulse", cfg_err, 1);
    cycle(0, 0, 0, 3);
    chk("cfg_err_gone", cfg_err, 0);
    chk("cfg_err_busy", busy, 0);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 7; i++) cycle(1, 0, 6, 3);
    #10;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(0, 0, 6, 3);
    chk("reset_idle_busy", busy, 0);

    // Randomized run.
    en_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 25 == 0) en_r = 1 - en_r;
      ab_r = ($urandom % 80 == 0) ? 1 : 0;
      m_r  = ($urandom % 10 == 0) ? 0 : 1 + int'($urandom % 7);
      cycle(en_r, ab_r, m_r, int'($urandom % 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
